// File: rtl/i_fetch.sv
// i_fetch: single-line-buffered instruction fetch unit with redirect and stall handling
module i_fetch (
    input  logic         clock,
    input  logic         nreset,
    output logic         rd_en,
    output logic [31:0]  pc_out,
    input  logic         icache_valid,
    input  logic [127:0] icache_data,
    input  logic         stall,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output logic         instr_valid,
    output logic [31:0]  instr,
    output logic [31:0]  instr_pc
);
    typedef enum logic [1:0] {S_RUN, S_REQ, S_RESP} state_t;
    state_t       state, state_nx;
    logic [31:0]  fetch_pc, fetch_pc_nx;
    logic [127:0] line_data;
    logic [27:0]  line_tag;
    logic         line_valid;
    logic         hit;
    logic         fill;
    assign hit         = line_valid && (line_tag == fetch_pc[31:4]);
    assign fill        = (state == S_RESP) && icache_valid && !redirect;
    assign rd_en       = (state != S_RUN);
    assign pc_out      = {fetch_pc[31:4], 4'h0};
    assign instr_pc    = fetch_pc;
    assign instr       = line_data[{fetch_pc[3:2], 5'd0} +: 32];
    // next state and next pc; redirect wins over everything, a hit in S_RUN streams
    always_comb begin
        instr_valid = (state == S_RUN) && hit && !redirect;
        state_nx    = redirect             ? S_RUN  :
                      (state == S_RUN)     ? (hit ? S_RUN : S_REQ) :
                      (state == S_REQ)     ? S_RESP :
                      icache_valid         ? S_RUN  : S_RESP;
        fetch_pc_nx = redirect                 ? (redirect_pc & ~32'h3) :
                      (instr_valid && !stall)  ? fetch_pc + 32'd4       : fetch_pc;
    end
    // fsm state and fetch pc registers
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state    <= S_RUN;
            fetch_pc <= 32'h0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
        end
    end
    // one-line buffer, loaded only by a completed fill that was not redirected away
    always_ff @(posedge clock) begin
        if (!nreset) begin
            line_data  <= '0;
            line_tag   <= '0;
            line_valid <= 1'b0;
        end else if (fill) begin
            line_data  <= icache_data;
            line_tag   <= fetch_pc[31:4];
            line_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_i_fetch.sv
// tb_i_fetch: scoreboard bench for i_fetch with a cache model and expected-pc reference
module tb_i_fetch;
    logic         clock;
    logic         nreset;
    logic         rd_en;
    logic [31:0]  pc_out;
    logic         icache_valid;
    logic [127:0] icache_data;
    logic         stall;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         instr_valid;
    logic [31:0]  instr;
    logic [31:0]  instr_pc;

    i_fetch dut (
        .clock(clock), .nreset(nreset), .rd_en(rd_en), .pc_out(pc_out),
        .icache_valid(icache_valid), .icache_data(icache_data), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc)
    );

    int checks = 0;
    int errors = 0;
    int fix_dly = 0;
    int dly = 0;
    int rd_cnt = 0;
    int idle = 0;
    logic [31:0] exp_q[$];
    logic        p_rd, p_fill, p_hc, p_cross, p_xm, consume;
    logic [31:0] p_rpc, ep;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a & ~32'h3) * 32'h9E3779B1) ^ 32'hC3A51F0E;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // cache model: answers once rd_en has been high for 2 cycles plus an optional hold-off
    always @(posedge clock) begin
        #1;
        rd_cnt = rd_en ? rd_cnt + 1 : 0;
        if (rd_cnt == 1)
            dly = (fix_dly >= 0) ? fix_dly : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        icache_valid = rd_en && (rd_cnt >= 2 + dly);
        for (int i = 0; i < 4; i++)
            icache_data[32*i +: 32] = icache_valid ? mem_word(pc_out + 32'(4 * i)) : $urandom;
    end

    task automatic drive(input logic n, input logic s, input logic r, input logic [31:0] rpc);
        @(posedge clock);
        #2;
        nreset = n;
        stall = s;
        redirect = r && n;
        redirect_pc = rpc;
        if (!n) begin
            exp_q.delete();
            exp_q.push_back(32'h0);
        end else if (r) begin
            exp_q.delete();
            exp_q.push_back(rpc & ~32'h3);
        end
    endtask

    task automatic go();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    // monitor: scoreboard compare on every valid instruction plus sequencing rules
    always @(negedge clock) begin
        if (!nreset) begin
            {p_rd, p_fill, p_hc, p_cross, p_xm} = '0;
            idle = 0;
        end else begin
            chk("pc_out_line", pc_out, {instr_pc[31:4], 4'h0});
            if (redirect) chk("iv_on_redirect", 32'(instr_valid), 32'h0);
            if (rd_en && !redirect && exp_q.size() > 0) chk("fill_addr", pc_out, {exp_q[0][31:4], 4'h0});
            if (p_rd) begin
                chk("redir_rd_en", 32'(rd_en), 32'h0);
                chk("redir_pc", instr_pc, p_rpc & ~32'h3);
            end
            if (p_fill) chk("fill_then_hit", 32'(instr_valid), 32'(!redirect));
            if (p_hc) chk("hit_continue", 32'(instr_valid), 32'(!redirect));
            if (p_cross) begin
                chk("cross_miss", 32'(instr_valid), 32'h0);
                chk("no_prefetch", 32'(rd_en), 32'h0);
            end
            if (p_xm) chk("miss_req", 32'(rd_en), 32'h1);
            ep = (exp_q.size() > 0) ? exp_q[0] : instr_pc;
            if (instr_valid) begin
                idle = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty got_pc=%h exp=none", instr_pc);
                end else begin
                    chk("sb_pc", instr_pc, exp_q[0]);
                    chk("sb_instr", instr, mem_word(exp_q[0]));
                end
            end else if (++idle > 200) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout got=%0d exp<=200", idle);
                idle = 0;
            end
            consume = instr_valid && !stall;
            p_xm    = p_cross && !redirect;
            p_cross = consume && (ep[3:2] == 2'b11);
            p_hc    = instr_valid && !p_cross;
            p_fill  = rd_en && icache_valid && !redirect;
            p_rd    = redirect;
            p_rpc   = redirect_pc;
            if (consume && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                exp_q.push_back(ep + 32'd4);
            end
        end
    end

    initial begin
        logic found;
        int n;
        nreset = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        chk("rst_rd_en", 32'(rd_en), 32'h0);
        chk("rst_iv", 32'(instr_valid), 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        // cold start
        go(); @(negedge clock);
        chk("cold_c0_rd", 32'(rd_en), 32'h0);
        chk("cold_c0_iv", 32'(instr_valid), 32'h0);
        go(); @(negedge clock);
        chk("cold_c1_rd", 32'(rd_en), 32'h1);
        chk("cold_c1_addr", pc_out, 32'h0);
        go(); @(negedge clock);
        chk("cold_c2_rd", 32'(rd_en), 32'h1);
        go(); @(negedge clock);
        chk("cold_c3_iv", 32'(instr_valid), 32'h1);
        chk("cold_w0", instr, mem_word(32'h0));
        go(); @(negedge clock);
        chk("cold_w1_pc", instr_pc, 32'h4);
        // stall at pc 8
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0); @(negedge clock);
            chk("stall_iv", 32'(instr_valid), 32'h1);
            chk("stall_pc", instr_pc, 32'h8);
            chk("stall_instr", instr, mem_word(32'h8));
        end
        go(); @(negedge clock);
        chk("stall_rel_pc", instr_pc, 32'h8);
        go(); @(negedge clock);
        chk("after_stall_pc", instr_pc, 32'hC);
        // line crossing
        go(); @(negedge clock);
        chk("cross_iv", 32'(instr_valid), 32'h0);
        go(); @(negedge clock);
        chk("cross_rd1", 32'(rd_en), 32'h1);
        chk("cross_addr", pc_out, 32'h10);
        go(); @(negedge clock);
        chk("cross_rd2", 32'(rd_en), 32'h1);
        go(); @(negedge clock);
        chk("cross_pc", instr_pc, 32'h10);
        chk("cross_iv2", 32'(instr_valid), 32'h1);
        // redirect in S_RESP with a same-cycle response
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #2;
            if (rd_en && icache_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("resp_found", 32'(found), 32'h1);
        redirect = 1'b1;
        redirect_pc = 32'h107;
        exp_q.delete();
        exp_q.push_back(32'h104);
        @(negedge clock);
        chk("rresp_iv", 32'(instr_valid), 32'h0);
        go(); @(negedge clock);
        chk("rresp_pc", instr_pc, 32'h104);
        chk("rresp_miss", 32'(instr_valid), 32'h0);
        go(); @(negedge clock);
        chk("rresp_fill_rd", 32'(rd_en), 32'h1);
        chk("rresp_fill_addr", pc_out, 32'h100);
        drive(1'b1, 1'b0, 1'b1, 32'h18);
        go(); @(negedge clock);
        chk("buffer_kept", 32'(instr_valid), 32'h1);
        chk("buffer_kept_pc", instr_pc, 32'h18);
        // cache holds off for 4 extra cycles
        fix_dly = 4;
        drive(1'b1, 1'b0, 1'b1, 32'h200);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            go(); @(negedge clock);
            if (rd_en) begin
                n++;
                chk("hold_addr", pc_out, 32'h200);
            end
            if (instr_valid) break;
        end
        chk("hold_len", 32'(n), 32'h6);
        // wrap at the top of the address space, then reset in the middle of a fill
        fix_dly = 3;
        drive(1'b1, 1'b0, 1'b1, 32'hFFFFFFFC);
        for (int i = 0; i < 30; i++) begin
            go(); @(negedge clock);
            if (instr_valid) break;
        end
        chk("wrap_top_pc", instr_pc, 32'hFFFFFFFC);
        go(); @(negedge clock);
        chk("wrap_pc", instr_pc, 32'h0);
        chk("wrap_miss", 32'(instr_valid), 32'h0);
        go(); @(negedge clock);
        chk("wrap_rd", 32'(rd_en), 32'h1);
        chk("wrap_addr", pc_out, 32'h0);
        go();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0); @(negedge clock);
        chk("midfill_rst_rd", 32'(rd_en), 32'h0);
        chk("midfill_rst_iv", 32'(instr_valid), 32'h0);
        chk("midfill_rst_pc", instr_pc, 32'h0);
        // randomized traffic
        fix_dly = -1;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2500; i++) begin
            logic [31:0] rpc;
            case ($urandom_range(0, 3))
                0: rpc = $urandom_range(0, 127);
                1: rpc = $urandom;
                2: rpc = 32'hFFFFFFF0 + $urandom_range(0, 15);
                default: rpc = $urandom_range(0, 63);
            endcase
            if ($urandom_range(0, 299) == 0)
                drive(1'b0, 1'b0, 1'b0, 32'h0);
            else
                drive(1'b1, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0, rpc);
        end
        repeat (5) go();
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
